// File: rtl/muldiv_if.sv
// EX-stage <-> multiply/divide unit connection: instruction issue, HI/LO moves and results.
interface muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             flush;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic             hilo_rd;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             stall;

  modport master (
    output start, flush, op, src_a, src_b, mthi, mtlo, wdata, hilo_rd,
    input  hi, lo, busy, done, stall
  );

  modport slave (
    input  start, flush, op, src_a, src_b, mthi, mtlo, wdata, hilo_rd,
    output hi, lo, busy, done, stall
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine with architectural HI/LO registers and pipeline stall.
// Optional MULDIV_FAST_MUL_EN: multiplies computed in one cycle, skipping the iterative CALC phase.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);
  localparam int unsigned W2 = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     count;
  logic              is_div, sign_a, neg_res, div_zero;
  logic [WIDTH-1:0]  orig_a, mag_b;
  logic [W2-1:0]     acc;
  logic [WIDTH-1:0]  hi_r, lo_r;
  logic              busy_r, done_r;

  // Operand sign/magnitude capture; only signed ops take magnitudes
  logic              sa_c, sb_c, accept_c, fast_c;
  logic [WIDTH-1:0]  mag_a_c, mag_b_c;

  assign sa_c     = !bus.op[0] && bus.src_a[WIDTH-1];
  assign sb_c     = !bus.op[0] && bus.src_b[WIDTH-1];
  assign mag_a_c  = sa_c ? -bus.src_a : bus.src_a;
  assign mag_b_c  = sb_c ? -bus.src_b : bus.src_b;
  assign accept_c = (state == IDLE) && bus.start && !bus.flush;

`ifdef MULDIV_FAST_MUL_EN
  assign fast_c = !bus.op[1];
`else
  assign fast_c = 1'b0;
`endif

  // One shift-add multiply step: add multiplier to upper half when LSB set, shift right
  logic [WIDTH:0]    mul_sum;
  logic [W2-1:0]     mul_nx;
  assign mul_sum = {1'b0, acc[W2-1:WIDTH]} + {1'b0, (acc[0] ? mag_b : {WIDTH{1'b0}})};
  assign mul_nx  = {mul_sum, acc[WIDTH-1:1]};

  // One restoring divide step: acc holds {remainder, dividend/quotient}
  logic [WIDTH:0]    div_diff;
  logic [W2-1:0]     div_nx;
  assign div_diff = acc[W2-1:WIDTH-1] - {1'b0, mag_b};
  assign div_nx   = div_diff[WIDTH] ? {acc[W2-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  // Sign correction applied in FIX
  logic [W2-1:0]     prod_fix;
  logic [WIDTH-1:0]  quo_fix, rem_fix, fix_hi, fix_lo;
  assign prod_fix = neg_res ? -acc : acc;
  assign quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = sign_a  ? -acc[W2-1:WIDTH] : acc[W2-1:WIDTH];

  always_comb begin
    fix_hi = prod_fix[W2-1:WIDTH];
    fix_lo = prod_fix[WIDTH-1:0];
    if (is_div) begin
      if (div_zero) begin
        fix_hi = orig_a;
        fix_lo = {WIDTH{1'b1}};
      end else begin
        fix_hi = rem_fix;
        fix_lo = quo_fix;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept_c) state_nx = fast_c ? FIX : CALC;
      CALC:    if (count == CW'(WIDTH - 1)) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath and HI/LO; a start in IDLE takes priority over MTHI/MTLO
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      is_div   <= 1'b0;
      sign_a   <= 1'b0;
      neg_res  <= 1'b0;
      div_zero <= 1'b0;
      orig_a   <= '0;
      mag_b    <= '0;
      acc      <= '0;
      hi_r     <= '0;
      lo_r     <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      busy_r <= (state_nx != IDLE);
      done_r <= (state == FIX);
      case (state)
        IDLE: begin
          if (accept_c) begin
            is_div   <= bus.op[1];
            sign_a   <= sa_c;
            neg_res  <= sa_c ^ sb_c;
            div_zero <= (bus.src_b == '0);
            orig_a   <= bus.src_a;
            mag_b    <= mag_b_c;
            count    <= '0;
            if (fast_c) acc <= W2'(mag_a_c) * W2'(mag_b_c);
            else        acc <= {{WIDTH{1'b0}}, mag_a_c};
          end else begin
            if (bus.mthi) hi_r <= bus.wdata;
            if (bus.mtlo) lo_r <= bus.wdata;
          end
        end
        CALC: begin
          count <= count + CW'(1);
          acc   <= is_div ? div_nx : mul_nx;
        end
        FIX: begin
          hi_r <= fix_hi;
          lo_r <= fix_lo;
        end
        default: ;
      endcase
    end
  end

  assign bus.hi    = hi_r;
  assign bus.lo    = lo_r;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.stall = busy_r && (bus.start || bus.hilo_rd || bus.mthi || bus.mtlo);
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors, stall/reset sequences, random ops vs. arithmetic model.
module tb_muldiv_unit;
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(32)) bus();
  muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_lat(input logic [1:0] op);
    return (FAST && !op[1]) ? 2 : 34;
  endfunction

  // Reference: plain 64-bit arithmetic with the architectural special cases; returns {hi, lo}
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: begin p = 64'(sa * sb); return p; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; return p; end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (op == 2'b10) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
          q = sa / sb;
          r = sa % sb;
          return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int done_cyc, output int busy_cyc);
    bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b;
    tick;
    bus.start = 1'b0;
    done_cyc = -1;
    busy_cyc = 0;
    for (int n = 1; n <= 60; n++) begin
      if (bus.done) begin
        done_cyc = n;
        break;
      end
      if (bus.busy) busy_cyc++;
      tick;
    end
  endtask

  task automatic do_vec(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int dc, bc;
    run_op(op, a, b, dc, bc);
    check({name, " latency"}, 64'(dc), 64'(exp_lat(op)));
    check({name, " busy"}, 64'(bc), 64'(exp_lat(op) - 1));
    check({name, " hi"}, 64'(bus.hi), 64'(eh));
    check({name, " lo"}, 64'(bus.lo), 64'(el));
  endtask

  vec_t vecs[$];

  initial begin
    int dc, bc, sc, lo_chg;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    logic [63:0] m;

    vecs.push_back('{"multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
    vecs.push_back('{"mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB});
    vecs.push_back('{"mult_min",  2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000});
    vecs.push_back('{"multu_0",   2'b01, 32'd0,         32'h1234_5678, 32'd0,         32'd0});
    vecs.push_back('{"div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD});
    vecs.push_back('{"div_negb",  2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD});
    vecs.push_back('{"divu",      2'b11, 32'd100,       32'd7,         32'd2,         32'd14});
    vecs.push_back('{"divu_zero", 2'b11, 32'h1234,      32'd0,         32'h1234,      32'hFFFF_FFFF});
    vecs.push_back('{"div_zero",  2'b10, 32'hFFFF_FFFF, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFF});
    vecs.push_back('{"div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000});

    bus.start = 1'b0; bus.flush = 1'b0; bus.op = 2'b00; bus.src_a = '0; bus.src_b = '0;
    bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wdata = '0; bus.hilo_rd = 1'b0;
    rst = 1'b1;
    repeat (3) tick;
    rst = 1'b0;
    check("reset hi", 64'(bus.hi), 64'd0);
    check("reset lo", 64'(bus.lo), 64'd0);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset stall", 64'(bus.stall), 64'd0);

    // Directed table; ops issued back to back in the done cycle
    foreach (vecs[i]) do_vec(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eh, vecs[i].el);
    tick;
    check("done one pulse", 64'(bus.done), 64'd0);

    // MTHI+MTLO together in IDLE
    bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'hA5A5_0001;
    tick;
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
    check("mthi both", 64'(bus.hi), 64'hA5A5_0001);
    check("mtlo both", 64'(bus.lo), 64'hA5A5_0001);

    // DIVU with a same-cycle MTHI (dropped), then MFHI/MTLO held during busy
    bus.start = 1'b1; bus.op = 2'b11; bus.src_a = 32'd100; bus.src_b = 32'd7;
    bus.mthi = 1'b1; bus.wdata = 32'h0000_DEAD;
    tick;
    bus.start = 1'b0; bus.mthi = 1'b0;
    check("start beats mthi", 64'(bus.hi), 64'hA5A5_0001);
    bus.hilo_rd = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'h55;
    sc = 0; lo_chg = 0; dc = -1;
    for (int n = 1; n <= 60; n++) begin
      if (bus.done) begin
        dc = n;
        break;
      end
      if (bus.stall) sc++;
      if (bus.lo !== 32'hA5A5_0001) lo_chg++;
      tick;
    end
    check("stall divu latency", 64'(dc), 64'd34);
    check("stall cycles", 64'(sc), 64'd33);
    check("lo held while busy", 64'(lo_chg), 64'd0);
    check("stall released", 64'(bus.stall), 64'd0);
    check("stall divu lo", 64'(bus.lo), 64'd14);
    check("stall divu hi", 64'(bus.hi), 64'd2);
    tick;
    bus.hilo_rd = 1'b0; bus.mtlo = 1'b0;
    check("replayed mtlo", 64'(bus.lo), 64'h55);

    // Reset mid-multiply aborts with no late result
    bus.start = 1'b1; bus.op = 2'b00; bus.src_a = 32'd5; bus.src_b = 32'd6;
    tick;
    bus.start = 1'b0;
    repeat (9) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("abort busy", 64'(bus.busy), 64'd0);
    check("abort done", 64'(bus.done), 64'd0);
    check("abort hi", 64'(bus.hi), 64'd0);
    check("abort lo", 64'(bus.lo), 64'd0);
    sc = 0;
    repeat (30) begin
      tick;
      if (bus.done || bus.busy) sc++;
    end
    check("abort no activity", 64'(sc), 64'd0);

    // start with flush in IDLE is ignored
    bus.start = 1'b1; bus.flush = 1'b1;
    tick;
    bus.start = 1'b0; bus.flush = 1'b0;
    sc = 0;
    repeat (3) begin
      if (bus.busy) sc++;
      tick;
    end
    check("flush ignored", 64'(sc), 64'd0);
    do_vec("mult_after_reset", 2'b00, 32'd5, 32'd6, 32'd0, 32'd30);

    // Random operations against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = -32'($urandom_range(1, 15));
        3: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        default: ;
      endcase
      m = model(rop, ra, rb);
      do_vec($sformatf("rand%0d op%0d %h/%h", i, rop, ra, rb), rop, ra, rb, m[63:32], m[31:0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
